// File: rtl/stage_pipe_reg.sv
// stage_pipe_reg: valid/ready pipeline stage with sync flush and stall counter; 1-cycle latency.
// Backpressure from out_ready; `define STAGE_SKID_EN adds a 2-entry skid so in_ready is a pure register.
module stage_pipe_reg #(
  parameter int unsigned PAYLOAD_W      = 130,
  parameter bit          CLEAR_ON_FLUSH = 1'b1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  input  logic                 flush,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [1:0]           occupancy
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic accept;
  logic emit;

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;

`ifdef STAGE_SKID_EN
  logic                 skid_valid;
  logic [PAYLOAD_W-1:0] skid_data;

  assign in_ready  = !skid_valid;
  assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid};

  // Skid only fills while main is stalled and drains into main, so order stays FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      if (CLEAR_ON_FLUSH) begin
        out_data  <= '0;
        skid_data <= '0;
      end
    end else if (!out_valid) begin
      if (accept) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end
    end else if (emit) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_data <= in_data;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end
`else
  assign in_ready  = !out_valid || out_ready;
  assign occupancy = {1'b0, out_valid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      if (CLEAR_ON_FLUSH) begin
        out_data <= '0;
      end
    end else if (accept) begin
      out_data  <= in_data;
      out_valid <= 1'b1;
    end else if (emit) begin
      out_valid <= 1'b0;
    end
  end
`endif

  // A flush cycle is a kill, not a stall, so it is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !flush && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_stage_pipe_reg.sv
// Scoreboard bench for stage_pipe_reg (small payload, 4-bit stall counter); follows STAGE_SKID_EN.
module tb_stage_pipe_reg;

`ifdef STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam int PW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_data;
  logic          flush;
  logic          cnt_clr;
  logic [CW-1:0] stall_cnt;
  logic [1:0]    occupancy;

  stage_pipe_reg #(.PAYLOAD_W(PW), .CLEAR_ON_FLUSH(1'b1), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .cnt_clr(cnt_clr), .stall_cnt(stall_cnt), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [PW-1:0] sb_q[$];
  int  exp_cnt = 0;
  bit  acc_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: compare at negedge against the model, update model, return #1 after posedge.
  task automatic step();
    logic    exp_rdy;
    logic    do_emit;
    logic [PW-1:0] exp_d;
    @(negedge clk);
    exp_rdy = SKID ? (sb_q.size() < 2) : (sb_q.size() == 0 || out_ready);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, sb_q.size() != 0);
    chk("occupancy", occupancy, sb_q.size());
    chk("stall_cnt", stall_cnt, exp_cnt);
    do_emit = (sb_q.size() != 0) && out_ready;
    if (do_emit) begin
      exp_d = sb_q.pop_front();
      chk("out_data", out_data, exp_d);
    end
    acc_last = in_valid && exp_rdy;
    if (flush) sb_q.delete();
    else if (acc_last) sb_q.push_back(in_data);
    if (cnt_clr) exp_cnt = 0;
    else if (!flush && !out_ready && out_valid === 1'b1 && exp_cnt < 15) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    flush = 1'b0; cnt_clr = 1'b0;
    #12;
    chk("rst_vld", out_valid, 1'b0);
    chk("rst_data", out_data, 16'h0);
    chk("rst_occ", occupancy, 2'd0);
    chk("rst_cnt", stall_cnt, 4'd0);
    chk("rst_rdy", in_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: streaming at full throughput
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = PW'(i);
      step();
    end
    in_valid = 1'b0;
    step(); step();
    chk("t1_stall", stall_cnt, 4'd0);

    // 2: hold under backpressure
    in_valid = 1'b1; in_data = 16'h000A; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("t2_stall", stall_cnt, 4'd5);
    chk("t2_data", out_data, 16'h000A);
    chk("t2_vld", out_valid, 1'b1);
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    out_ready = 1'b1; step(); step();

    // 3: skid build then ordered drain
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 16'h000A; step();
    in_data = 16'h000B; step();
    in_data = 16'h000C; step();
    chk("t3_occ", occupancy, SKID ? 2'd2 : 2'd1);
    chk("t3_rdy", in_ready, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 8 && in_valid; i++) begin
      step();
      if (acc_last && in_data == 16'h000C) in_valid = 1'b0;
    end
    chk("t3_c_acc", in_valid, 1'b0);
    for (int i = 0; i < 4; i++) step();
    chk("t3_drained", sb_q.size(), 0);

    // 4: flush with full stage, offered payload discarded
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 16'h0011; step();
    in_data = 16'h0022; step();
    flush = 1'b1; in_data = 16'h0055; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t4_vld", out_valid, 1'b0);
    chk("t4_occ", occupancy, 2'd0);
    chk("t4_data", out_data, 16'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    // flush while emitting: emit completes, accepted 0x66 is dropped
    in_valid = 1'b1; in_data = 16'h0007; step();
    flush = 1'b1; in_data = 16'h0066; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t4b_vld", out_valid, 1'b0);
    step(); step();

    // 5: counter saturation and clear-over-increment
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0009; step();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("t5_sat", stall_cnt, 4'd15);
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    chk("t5_clr", stall_cnt, 4'd0);
    out_ready = 1'b1; step(); step();

    // 6: asynchronous reset between edges
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h003C; step();
    in_valid = 1'b0;
    chk("t6_pre", occupancy, 2'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_vld", out_valid, 1'b0);
    chk("t6_data", out_data, 16'h0);
    chk("t6_occ", occupancy, 2'd0);
    chk("t6_cnt", stall_cnt, 4'd0);
    sb_q.delete();
    exp_cnt = 0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b1; in_data = 16'h0101; step();
    in_data = 16'h0202; step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
